clk_fx_gen: RTL and testbench

Single-clock, synthesizable stand-in for the Spartan-3 DCM_SP frequency synthesizer. It derives a fractional-rate clock-enable (CLKFX_MULTIPLY/CLKFX_DIVIDE of CLKIN) with a phase accumulator. Logic that would otherwise run on a DCM-generated pixel clock runs on CLKIN gated by this enable; for example, 25 MHz from 32 MHz with 25/32. It sits at the top level between the board oscillator and the VGA timing logic.

---
 rtl/clk_fx_pkg.sv | 20 ++
 rtl/clk_fx_gen_if.sv | 29 ++
 rtl/clk_fx_lock_timer.sv | 36 +++
 rtl/clk_fx_gen.sv | 98 +++++++++
 tb/tb_clk_fx_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/clk_fx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_fx_pkg
// Purpose  : Shared defaults and width helper for the clk_fx_gen slice.
// Revision : 1.0 - initial release
// ============================================================================
package clk_fx_pkg;

  localparam int CLKFX_M_DEF     = 25;
  localparam int CLKFX_D_DEF     = 32;
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int LOCK_CNT_W      = 16;

  // One bit wider than needed for D-1, so acc + M (at most 2D-1) never wraps.
  function automatic int acc_width(input int d);
    return (d <= 1) ? 1 : $clog2(d) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_fx_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_fx_gen_if
// Purpose  : Output bundle of the fractional clock-enable generator.
// Revision : 1.0 - initial release
// ============================================================================
interface clk_fx_gen_if;

  logic CLK0;
  logic CLKFX_EN;
  logic CLKFX_TGL;
  logic LOCKED;

  modport master (
    output CLK0,
    output CLKFX_EN,
    output CLKFX_TGL,
    output LOCKED
  );

  modport slave (
    input CLK0,
    input CLKFX_EN,
    input CLKFX_TGL,
    input LOCKED
  );

endinterface
`default_nettype wire

// File: rtl/clk_fx_lock_timer.sv
`default_nettype none
// ============================================================================
// Module   : clk_fx_lock_timer
// Purpose  : Saturating post-reset counter that raises locked after
//            LOCK_CYCLES edges and holds it until reset.
// Revision : 1.0 - initial release
// ============================================================================
module clk_fx_lock_timer
  import clk_fx_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic CLKIN,
  input  logic RST_N,
  output logic locked
);

  localparam logic [LOCK_CNT_W-1:0] LAST_CNT = LOCK_CNT_W'(LOCK_CYCLES - 1);

  logic [LOCK_CNT_W-1:0] count;

  // Counting stops once locked, leaving count parked at LOCK_CYCLES.
  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      count  <= '0;
      locked <= 1'b0;
    end else if (!locked) begin
      count <= count + 1'b1;
      if (count == LAST_CNT) begin
        locked <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_fx_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_fx_gen
// Purpose  : DCM_SP CLKFX stand-in: phase-accumulator clock enable giving
//            CLKFX_MULTIPLY pulses per CLKFX_DIVIDE cycles of CLKIN.
// Options  : CLKFX_GEN_LOCK_GATE_EN - hold the accumulator until LOCKED.
// Revision : 1.0 - initial release
// ============================================================================
module clk_fx_gen
  import clk_fx_pkg::*;
#(
  parameter int CLKFX_MULTIPLY = CLKFX_M_DEF,
  parameter int CLKFX_DIVIDE   = CLKFX_D_DEF,
  parameter int LOCK_CYCLES    = LOCK_CYCLES_DEF
) (
  input  logic          CLKIN,
  input  logic          RST_N,
  input  logic          CLKFB,
  clk_fx_gen_if.master  fx
);

  localparam int              ACC_W = acc_width(CLKFX_DIVIDE);
  localparam logic [ACC_W-1:0] M_W  = ACC_W'(CLKFX_MULTIPLY);
  localparam logic [ACC_W-1:0] D_W  = ACC_W'(CLKFX_DIVIDE);

  generate
    if (CLKFX_MULTIPLY < 1 || CLKFX_DIVIDE < 1 || CLKFX_DIVIDE > 256 ||
        CLKFX_MULTIPLY > 255 || CLKFX_MULTIPLY > CLKFX_DIVIDE) begin : g_bad_ratio
      $error("clk_fx_gen: illegal ratio M=%0d D=%0d", CLKFX_MULTIPLY, CLKFX_DIVIDE);
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
      $error("clk_fx_gen: illegal LOCK_CYCLES=%0d", LOCK_CYCLES);
    end
  endgenerate

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] sum;
  logic             fx_en;
  logic             fx_en_next;
  logic             fx_tgl;
  logic             fx_tgl_next;
  logic             locked;
  logic             run;

  // Feedback pin exists only so the port list matches the DCM primitive.
  logic unused_clkfb;
  assign unused_clkfb = CLKFB;

  clk_fx_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .CLKIN  (CLKIN),
    .RST_N  (RST_N),
    .locked (locked)
  );

`ifdef CLKFX_GEN_LOCK_GATE_EN
  assign run = locked;
`else
  assign run = 1'b1;
`endif

  always_comb begin
    acc_next    = acc;
    fx_en_next  = 1'b0;
    fx_tgl_next = fx_tgl;
    sum         = acc + M_W;
    if (run) begin
      if (sum >= D_W) begin
        acc_next    = sum - D_W;
        fx_en_next  = 1'b1;
        fx_tgl_next = ~fx_tgl;
      end else begin
        acc_next = sum;
      end
    end
  end

  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      acc    <= '0;
      fx_en  <= 1'b0;
      fx_tgl <= 1'b0;
    end else begin
      acc    <= acc_next;
      fx_en  <= fx_en_next;
      fx_tgl <= fx_tgl_next;
    end
  end

  assign fx.CLK0      = CLKIN;
  assign fx.CLKFX_EN  = fx_en;
  assign fx.CLKFX_TGL = fx_tgl;
  assign fx.LOCKED    = locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_fx_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_fx_gen
// Purpose  : Self-checking bench for clk_fx_gen at three ratios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_fx_gen;

  localparam int LOCK = 16;
`ifdef CLKFX_GEN_LOCK_GATE_EN
  localparam int W0 = LOCK + 1;
`else
  localparam int W0 = 1;
`endif

  typedef struct {
    int   dut;
    int   edge_n;
    logic en;
    logic tgl;
    logic lk;
  } vec_t;

  typedef struct {
    int         dut;
    int         k;
    logic [2:0] outs;
  } exp_t;

  logic CLKIN;
  logic RST_N;
  logic CLKFB;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];
  exp_t sb[$];

  clk_fx_gen_if fx_a ();
  clk_fx_gen_if fx_b ();
  clk_fx_gen_if fx_c ();

  clk_fx_gen #(.CLKFX_MULTIPLY(25), .CLKFX_DIVIDE(32), .LOCK_CYCLES(LOCK)) dut_a (
    .CLKIN(CLKIN), .RST_N(RST_N), .CLKFB(CLKFB), .fx(fx_a));
  clk_fx_gen #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(4), .LOCK_CYCLES(LOCK)) dut_b (
    .CLKIN(CLKIN), .RST_N(RST_N), .CLKFB(CLKFB), .fx(fx_b));
  clk_fx_gen #(.CLKFX_MULTIPLY(8), .CLKFX_DIVIDE(8), .LOCK_CYCLES(LOCK)) dut_c (
    .CLKIN(CLKIN), .RST_N(RST_N), .CLKFB(CLKFB), .fx(fx_c));

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  // Closed-form reference: pulse k happens when floor(k*M/D) steps up.
  function automatic exp_t model(input int d, input int k);
    exp_t e;
    int m, dd, ka;
    m  = (d == 0) ? 25 : (d == 1) ? 1 : 8;
    dd = (d == 0) ? 32 : (d == 1) ? 4 : 8;
`ifdef CLKFX_GEN_LOCK_GATE_EN
    ka = (k > LOCK) ? k - LOCK : 0;
`else
    ka = k;
`endif
    e.dut     = d;
    e.k       = k;
    e.outs[2] = (ka > 0) && (((ka * m) / dd) != (((ka - 1) * m) / dd));
    e.outs[1] = (((ka * m) / dd) % 2) == 1;
    e.outs[0] = (k >= LOCK);
    return e;
  endfunction

  function automatic logic [2:0] get_out(input int d);
    case (d)
      0:       return {fx_a.CLKFX_EN, fx_a.CLKFX_TGL, fx_a.LOCKED};
      1:       return {fx_b.CLKFX_EN, fx_b.CLKFX_TGL, fx_b.LOCKED};
      default: return {fx_c.CLKFX_EN, fx_c.CLKFX_TGL, fx_c.LOCKED};
    endcase
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic add(input int d, input int k, input logic en, input logic tgl, input logic lk);
    vec_t v;
    v = '{d, k, en, tgl, lk};
    tbl.push_back(v);
  endtask

  task automatic run_edges(input int n, input bit first);
    exp_t e;
    int   win0 = 0;
    int   win1 = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge CLKIN);
      for (int d = 0; d < 3; d++) sb.push_back(model(d, k));
      #1;
      check("clk0_high", {7'd0, fx_a.CLK0}, 8'd1);
      CLKFB = 1'($urandom);
      @(negedge CLKIN);
      check("clk0_low", {7'd0, fx_b.CLK0}, 8'd0);
      CLKFB = 1'($urandom);
      for (int d = 0; d < 3; d++) begin
        if (sb.size() == 0) begin
          check($sformatf("sb_empty_d%0d_k%0d", d, k), 8'd1, 8'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("sb_d%0d_k%0d", e.dut, e.k), {5'd0, get_out(e.dut)}, {5'd0, e.outs});
        end
      end
      for (int t = 0; t < tbl.size(); t++) begin
        if (tbl[t].edge_n == k) begin
          check($sformatf("vec%0d_d%0d_k%0d", t, tbl[t].dut, k), {5'd0, get_out(tbl[t].dut)},
                {5'd0, tbl[t].en, tbl[t].tgl, tbl[t].lk});
        end
      end
      if (first) begin
        if (k >= W0 && k < W0 + 32)      win0 += int'(fx_a.CLKFX_EN);
        if (k >= W0 + 32 && k < W0 + 64) win1 += int'(fx_a.CLKFX_EN);
        if (k == W0 + 31) begin
          check("window0_pulses", 8'(win0), 8'd25);
          check("window0_acc", 8'(dut_a.acc), 8'd0);
        end
        if (k == W0 + 63) begin
          check("window1_pulses", 8'(win1), 8'd25);
          check("window1_acc", 8'(dut_a.acc), 8'd0);
        end
      end
    end
  endtask

  initial begin
`ifdef CLKFX_GEN_LOCK_GATE_EN
    add(1, 15, 0, 0, 0); add(1, 16, 0, 0, 1); add(1, 19, 0, 0, 1);
    add(1, 20, 1, 1, 1); add(1, 24, 1, 0, 1);
    add(0, 16, 0, 0, 1); add(0, 17, 0, 0, 1); add(0, 18, 1, 1, 1); add(0, 19, 1, 0, 1);
    add(2, 16, 0, 0, 1); add(2, 17, 1, 1, 1); add(2, 18, 1, 0, 1);
`else
    add(0, 1, 0, 0, 0); add(0, 2, 1, 1, 0); add(0, 3, 1, 0, 0);
    add(0, 4, 1, 1, 0); add(0, 5, 0, 1, 0);
    add(1, 3, 0, 0, 0); add(1, 4, 1, 1, 0); add(1, 8, 1, 0, 0);
    add(1, 12, 1, 1, 0); add(1, 15, 0, 1, 0); add(1, 16, 1, 0, 1);
    add(2, 1, 1, 1, 0); add(2, 2, 1, 0, 0); add(2, 3, 1, 1, 0);
`endif

    RST_N = 1'b0;
    CLKFB = 1'b0;
    repeat (5) @(posedge CLKIN);
    @(negedge CLKIN);
    for (int d = 0; d < 3; d++) check($sformatf("reset_hold_d%0d", d), {5'd0, get_out(d)}, 8'd0);

    RST_N = 1'b1;
    run_edges(96, 1'b1);

    // Pull reset between edges while dut_c is pulsing; outputs must clear at once.
    check("pre_async_en_c", {7'd0, fx_c.CLKFX_EN}, 8'd1);
    #2 RST_N = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("async_rst_d%0d", d), {5'd0, get_out(d)}, 8'd0);
    repeat (2) @(negedge CLKIN);
    for (int d = 0; d < 3; d++) check($sformatf("rst_held_d%0d", d), {5'd0, get_out(d)}, 8'd0);
    RST_N = 1'b1;
    run_edges(24, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
